// File: rtl/dmem_bytelane.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bytelane
// Brief    : Little-endian word RAM with byte/half/word stores, extending
//            loads, a registered read port and a post-reset clear sequencer.
//            Optional macro DMEM_ALIGN_CHECK_EN enables misalignment trapping.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bytelane #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        w_ena,
  input  logic [1:0]  dm_size,
  input  logic        dm_sext,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        rvalid,
  output logic        busy,
  output logic        misalign
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [AW-1:0] c_LAST_IDX = AW'(DEPTH_WORDS - 1);

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;
  logic [31:0]   r_rdata;
  logic          r_rvalid;
  logic          r_misalign;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [AW-1:0] w_idx;
  logic [1:0]    w_off;
  logic          w_mis;
  logic [31:0]   w_rword;
  logic [31:0]   w_shift;
  logic [31:0]   w_load;
  logic [3:0]    w_lane_be;
  logic [31:0]   w_lane_dat;
  logic          w_we;
  logic [AW-1:0] w_widx;
  logic [3:0]    w_wbe;
  logic [31:0]   w_wdat;
  logic          w_unused;

  assign w_unused = ^dm_addr[31:AW+2];
  assign w_idx    = dm_addr[AW+1:2];

  // Low address bits the access really uses; when checking is enabled a
  // legal half/word access already has these bits at zero.
  always_comb begin
    w_off = 2'b00;
    case (dm_size)
      2'b00:   w_off = dm_addr[1:0];
      2'b01:   w_off = {dm_addr[1], 1'b0};
      default: w_off = 2'b00;
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_mis = (dm_size == 2'b11) ||
                 ((dm_size == 2'b01) && dm_addr[0]) ||
                 ((dm_size == 2'b10) && (dm_addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  assign w_rword = r_mem[w_idx];
  assign w_shift = w_rword >> {w_off, 3'b000};

  always_comb begin
    w_load = w_rword;
    case (dm_size)
      2'b00:   w_load = {{24{dm_sext & w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_load = {{16{dm_sext & w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_rword;
    endcase
  end

  // Store data is replicated across lanes so the enables alone pick the target.
  always_comb begin
    w_lane_be  = 4'b1111;
    w_lane_dat = dm_wdata;
    case (dm_size)
      2'b00: begin
        w_lane_be  = 4'b0001 << w_off;
        w_lane_dat = {4{dm_wdata[7:0]}};
      end
      2'b01: begin
        w_lane_be  = 4'b0011 << w_off;
        w_lane_dat = {2{dm_wdata[15:0]}};
      end
      default: begin
        w_lane_be  = 4'b1111;
        w_lane_dat = dm_wdata;
      end
    endcase
  end

  always_comb begin
    w_we   = 1'b0;
    w_widx = r_cnt;
    w_wbe  = 4'b1111;
    w_wdat = 32'h0;
    if (r_state == ST_CLEAR) begin
      w_we = !rst;
    end else begin
      w_we   = !rst && ena && w_ena && !w_mis;
      w_widx = w_idx;
      w_wbe  = w_lane_be;
      w_wdat = w_lane_dat;
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (w_we && w_wbe[l]) begin
        r_mem[w_widx][l*8 +: 8] <= w_wdat[l*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_CLEAR;
      r_cnt      <= '0;
      r_busy     <= 1'b1;
      r_rdata    <= 32'h0;
      r_rvalid   <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_rvalid   <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST_IDX) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
          end
        end
        ST_READY: begin
          if (ena) begin
            if (w_mis) begin
              r_misalign <= 1'b1;
            end else if (!w_ena) begin
              r_rdata  <= w_load;
              r_rvalid <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign dm_rdata = r_rdata;
  assign rvalid   = r_rvalid;
  assign busy     = r_busy;
  assign misalign = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bytelane.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_bytelane
// Brief    : Self-checking bench for dmem_bytelane against a byte-addressed
//            reference memory (honours DMEM_ALIGN_CHECK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_bytelane;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        w_ena = 1'b0;
  logic [1:0]  dm_size = 2'b10;
  logic        dm_sext = 1'b0;
  logic [31:0] dm_addr = 32'h0;
  logic [31:0] dm_wdata = 32'h0;
  logic [31:0] dm_rdata;
  logic        rvalid;
  logic        busy;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mb [DEPTH*4];
  logic [31:0] exp_rdata = 32'h0;

  dmem_bytelane #(.DEPTH_WORDS(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .w_ena    (w_ena),
    .dm_size  (dm_size),
    .dm_sext  (dm_sext),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .rvalid   (rvalid),
    .busy     (busy),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // First byte touched: word index wraps modulo DEPTH, low bits rounded down to the size.
  function automatic int base_byte(input logic [1:0] sz, input logic [31:0] a);
    int wi, off;
    wi  = int'(a >> 2) % DEPTH;
    off = int'(a % 4);
    if (sz == 2'd1) off = off - (off % 2);
    else if (sz != 2'd0) off = 0;
    return wi * 4 + off;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
    exp_rdata = 32'h0;
  endtask

  task automatic access(input logic we, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd);
    bit mis;
    int b, n;
    logic [31:0] v;
    ena = 1'b1; w_ena = we; dm_size = sz; dm_sext = sx; dm_addr = a; dm_wdata = wd;
    mis = model_mis(sz, a);
    b = base_byte(sz, a);
    n = nbytes(sz);
    if (!mis) begin
      if (we) begin
        for (int k = 0; k < n; k++) mb[b+k] = wd[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < n; k++) v = v | (32'(mb[b+k]) << (8*k));
        if (n < 4 && sx && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        exp_rdata = v;
      end
    end
    tick();
    chk("rvalid", 32'(rvalid), 32'(!we && !mis));
    chk("misalign", 32'(misalign), 32'(mis));
    chk("rdata", dm_rdata, exp_rdata);
  endtask

  task automatic idle();
    ena = 1'b0;
    tick();
    chk("idle_rvalid", 32'(rvalid), 32'h0);
  endtask

  // Counts cycles with busy high, starting right after the edge that sampled rst.
  task automatic wait_clear(input string tag);
    int bc;
    bit saw;
    bc = 1; saw = 1'b0;
    ena = 1'b1; w_ena = 1'b0; dm_size = 2'd2; dm_addr = 32'h0;
    for (int i = 0; i < 200 && busy; i++) begin
      tick();
      if (busy) bc++;
      if (rvalid) saw = 1'b1;
    end
    chk({tag, "_busy_len"}, 32'(bc), 32'd64);
    chk({tag, "_no_rvalid"}, 32'(saw), 32'h0);
    ena = 1'b0;
  endtask

  initial begin
    logic [1:0] sz;
    model_clear();
    rst = 1'b1;
    tick();
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", dm_rdata, 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    rst = 1'b0;
    wait_clear("clear");

    for (int i = 0; i < DEPTH; i++) access(1'b0, 2'd2, 1'b0, 32'(i*4), 32'h0);
    idle();

    access(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
    access(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00AB);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("lane_byte", dm_rdata, 32'h11AB_3344);
    access(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("lane_half", dm_rdata, 32'hBEEF_3344);

    access(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF_7F01);
    access(1'b0, 2'd0, 1'b1, 32'h22, 32'h0);
    chk("ext_lb", dm_rdata, 32'hFFFF_FFFF);
    access(1'b0, 2'd0, 1'b0, 32'h22, 32'h0);
    chk("ext_lbu", dm_rdata, 32'h0000_00FF);
    access(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    chk("ext_lh", dm_rdata, 32'hFFFF_80FF);
    access(1'b0, 2'd0, 1'b1, 32'h21, 32'h0);
    chk("ext_lb_pos", dm_rdata, 32'h0000_007F);
    idle();

    access(1'b1, 2'd2, 1'b0, 32'h100, 32'hCAFE_F00D);
    access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    chk("wrap", dm_rdata, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) access(1'b0, 2'd2, 1'b0, 32'(i*4 + 16), 32'h0);
    idle();

    access(1'b1, 2'd2, 1'b0, 32'h21, 32'h1234_5678);
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_store", dm_rdata, 32'h80FF_7F01);
`else
    chk("mis_store", dm_rdata, 32'h1234_5678);
`endif
    idle();

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) idle();
      sz = 2'($urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 511)), $urandom);
    end
    idle();

    // Reset on the same edge as a load: no rvalid, then restart mid-clear.
    ena = 1'b1; w_ena = 1'b0; dm_size = 2'd2; dm_addr = 32'h10; rst = 1'b1;
    tick();
    chk("rst_load_rvalid", 32'(rvalid), 32'h0);
    chk("rst_load_rdata", dm_rdata, 32'h0);
    rst = 1'b0; ena = 1'b0;
    model_clear();
    for (int i = 0; i < 30; i++) tick();
    chk("midclear_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear("midclear");
    for (int i = 0; i < 8; i++) access(1'b0, 2'd2, 1'b0, 32'($urandom_range(0, 255)), 32'h0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_bytelane.md
# dmem_bytelane

Parametrised successor to the single-port data memory: a word-organised, little-endian data RAM with byte, halfword and word stores, sign- or zero-extending loads, and a registered read port. After reset it zeroes the whole array with a clear sequencer before accepting accesses. It sits in the MEM stage of the static pipeline, which stalls on `busy` and samples `dm_rdata` when `rvalid` is high.

## Interface
- `DEPTH_WORDS`, default 64: number of 32-bit words. Must be a power of two and at least 4.
- `AW`, default `$clog2(DEPTH_WORDS)`: word-index width. Derived; do not override.
- `clk` input, 1 bit: the only clock. All state changes on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `ena` input, 1 bit: access request, qualified by `!busy`.
- `w_ena` input, 1 bit: 1 means store, 0 means load. Only meaningful when `ena` is high.
- `dm_size` input, 2 bits: 00 byte, 01 halfword, 10 word, 11 reserved.
- `dm_sext` input, 1 bit: load extension. 1 sign-extends, 0 zero-extends. Ignored for word loads and for stores.
- `dm_addr` input, 32 bits: byte address. Word index is `dm_addr[AW+1:2]`; bits above that are ignored, so addresses wrap.
- `dm_wdata` input, 32 bits: store data, right-justified. Byte stores use `[7:0]`; halfword stores use `[15:0]`.
- `dm_rdata` output, 32 bits: registered, extended load result.
- `rvalid` output, 1 bit: one-cycle pulse marking `dm_rdata` valid.
- `busy` output, 1 bit: high while the clear sequencer runs.
- `misalign` output, 1 bit: one-cycle pulse on a misaligned access. Only active when the alignment check is compiled in.

## Operation
- FSM states: CLEAR and READY.
  - `rst` forces CLEAR and sets the clear counter to 0.
  - In CLEAR, each cycle writes 0 to word[counter] and increments the counter.
  - After word `DEPTH_WORDS-1` is written, the FSM moves to READY.
  - READY is held until the next `rst`.
- `busy` is 1 exactly while in CLEAR. `ena` is ignored in CLEAR: no write, no `rvalid`.
- Store (READY, `ena && w_ena`): byte enables are derived from the size and `dm_addr[1:0]`.
  - Byte: lane `addr[1:0]` gets `wdata[7:0]`.
  - Halfword: lanes `{addr[1],0}` and `{addr[1],1}` get `wdata[15:0]`, lower byte at the lower address.
  - Word: all four lanes.
  - Lanes that are not enabled keep their contents.
- Load (READY, `ena && !w_ena`): the addressed word is read. The byte or halfword is selected by `addr[1:0]`, then extended per `dm_sext`, and registered into `dm_rdata`.
- `dm_rdata` holds its last value until the next load completes. Stores never change `dm_rdata`.
- Size 11 is always treated as misaligned.
- Store followed by a load of the same word on the next cycle returns the newly stored bytes. No hazard exists because the port is single-port.

## Timing
- Reset values: `dm_rdata`=0, `rvalid`=0, `misalign`=0, `busy`=1.
- `busy` stays high for `DEPTH_WORDS` cycles after the cycle in which `rst` is sampled high. It falls at the edge that completes the last clear write.
- Load latency is 1: a request sampled at edge N gives valid `dm_rdata` and `rvalid`=1 after edge N, and `rvalid`=0 after edge N+1 unless another load is issued.
- Back-to-back loads give one result per cycle.
- Store latency is 1: the write happens at the edge where it is sampled.
- `rst` asserted mid-CLEAR restarts the counter at 0. `rst` asserted during a load suppresses that `rvalid`.
- If `ena` is high on the same edge that `busy` falls, the request is ignored. The first accepted request is the one sampled with `busy`=0.

## Configuration
- Macro `DMEM_ALIGN_CHECK_EN` selects alignment handling.
- Defined: the following are misaligned.
  - Halfword with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
  - Size 11.
- Defined, on a misaligned access:
  - Memory is not written.
  - `dm_rdata` is unchanged.
  - `rvalid` is 0.
  - `misalign` pulses 1 for one cycle, with the same latency as `rvalid`.
- Undefined: misaligned low address bits are forced to zero. Halfword uses `addr[1]` only; word ignores `addr[1:0]`; size 11 behaves as word. `misalign` is tied 0.

## Test plan
- Reset and clear, `DEPTH_WORDS`=64: deassert `rst` → `busy` high exactly 64 cycles. Then word-load of every address → 0, each with `rvalid` pulsing 1 cycle after the request.
- Byte lanes: word-store 0x11223344 at 0x10, then byte-store 0xAB at 0x12 → word load at 0x10 = 0x11AB3344. Halfword-store 0xBEEF at 0x12 → 0xBEEF3344.
- Extension: word 0x80FF7F01 at 0x20. Load byte at 0x22 with `dm_sext`=1 → 0xFFFFFFFF; with `dm_sext`=0 → 0x000000FF. Load halfword at 0x22 with `dm_sext`=1 → 0xFFFF80FF.
- Wrap and throughput: store 0xCAFEF00D at byte address 0x100 (DEPTH 64) → word load at 0x0 returns it. Four back-to-back loads → four consecutive `rvalid` cycles.
- Reset mid-clear: assert `rst` at clear cycle 30 → `busy` lasts 64 further cycles. A request during `busy` → no `rvalid`.
- With `DMEM_ALIGN_CHECK_EN`: word store at 0x21 → `misalign` pulse, memory unchanged. Without the macro: the same store lands at 0x20, `misalign` stays 0.
